// File: rtl/enc_rr_arb2bin.sv
// Round-robin arbiter over N requesters with a registered binary grant index.
// Each grant is locked until release and is followed by one idle bubble.
module enc_rr_arb2bin #(
  parameter int N        = 15,
  parameter int W        = 4,
  parameter int MAX_HOLD = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         done_i,
  output logic         gnt_valid_o,
  output logic [W-1:0] gnt_idx_o,
  output logic         gnt_timeout_o
);

  localparam int WP = W + 1;
  localparam logic [7:0] WD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [7:0]   hold_q, hold_d;
  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic         to_q, to_d;

  logic         found;
  logic [W-1:0] win;
  logic [WP-1:0] scan;
  logic         rel_done, rel_drop, rel_wd;

  // Scan from ptr upward, wrapping modulo N so indices >= N never appear.
  always_comb begin
    found = 1'b0;
    win   = '0;
    scan  = '0;
    for (int k = 0; k < N; k++) begin
      scan = {1'b0, ptr_q} + WP'(k);
      if (scan >= WP'(N)) scan = scan - WP'(N);
      if (!found && req_i[scan[W-1:0]]) begin
        found = 1'b1;
        win   = scan[W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    to_d     = 1'b0;
    rel_done = done_i;
    rel_drop = !req_i[idx_q];
    rel_wd   = (MAX_HOLD != 0) && (hold_q == WD_LAST);
    unique case (state_q)
      IDLE: begin
        if (found) begin
          idx_d   = win;
          valid_d = 1'b1;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (rel_done || rel_drop || rel_wd) begin
          valid_d = 1'b0;
          ptr_d   = (idx_q == W'(N - 1)) ? '0 : idx_q + W'(1);
          to_d    = rel_wd && !rel_done && !rel_drop;
          state_d = IDLE;
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_valid_o   = valid_q;
    gnt_idx_o     = idx_q;
    gnt_timeout_o = to_q;
  end

endmodule
